// File: rtl/gpo_seq_pkg.sv
// Shared types and constants for the GPO pattern sequencer slot core.
package gpo_seq_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] ADDR_CTRL       = 5'd0;
  localparam logic [4:0] ADDR_PRESCALE   = 5'd1;
  localparam logic [4:0] ADDR_LENGTH     = 5'd2;
  localparam logic [4:0] ADDR_STATUS     = 5'd3;
  localparam logic [4:0] ADDR_IDLE       = 5'd4;
  localparam logic [4:0] ADDR_TABLE_BASE = 5'd16;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_LOOP     = 2;
  localparam int CTRL_CLR_DONE = 3;
  localparam int CTRL_BUSY     = 0;
  localparam int CTRL_DONE     = 4;

  localparam int DUR_W = 16;

endpackage

// File: rtl/gpo_seq_prescaler.sv
// Tick generator: one single-cycle tick every limit+1 enabled clocks.
module gpo_seq_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] limit,
  input  logic        enable,
  input  logic        clear,
  output logic        tick
);

  logic [31:0] cnt;

  // Compare against the live limit so a rewritten prescale applies at once.
  assign tick = enable && (cnt >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (clear || !enable || tick) cnt <= '0;
    else                              cnt <= cnt + 32'd1;
  end

endmodule

// File: rtl/mmio_gpo_seq.sv
// MMIO slot that plays a (value, duration) table onto the GPO pins.
// Define GPO_SEQ_IRQ_EN to add the o_irq output mirroring the done flag.
module mmio_gpo_seq
  import gpo_seq_pkg::*;
#(
  parameter int GPO_W = 16,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cs,
  input  logic             i_write,
  input  logic             i_read,
  input  logic [4:0]       i_addr,
  input  logic [31:0]      i_write_data,
  output logic [31:0]      o_read_data,
  output logic [GPO_W-1:0] o_gpo
`ifdef GPO_SEQ_IRQ_EN
  ,
  output logic             o_irq
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, next_idx, load_idx, rd_idx;
  logic [DUR_W-1:0]   dur_cnt;
  logic [15:0]        loop_cnt;
  logic               done, loop_en;
  logic [31:0]        prescale;
  logic [4:0]         length;
  logic [GPO_W-1:0]   idle_val, idle_next, gpo_d;
  logic [GPO_W-1:0]   tbl_val [DEPTH];
  logic [DUR_W-1:0]   tbl_dur [DEPTH];

  logic wr_en, ctrl_wr, start_req, stop_req, clr_req, len_ok, tbl_hit, addr_in_tbl;
  logic tick, start_go, step, last, finish, wrap, load;
  logic unused_read;

  assign unused_read = i_read;

  assign wr_en       = i_cs & i_write;
  assign ctrl_wr     = wr_en && (i_addr == ADDR_CTRL);
  assign start_req   = ctrl_wr && i_write_data[CTRL_START];
  assign stop_req    = ctrl_wr && i_write_data[CTRL_STOP];
  assign clr_req     = ctrl_wr && i_write_data[CTRL_CLR_DONE];
  assign len_ok      = (length != '0) && (32'(length) <= 32'(DEPTH));
  assign rd_idx      = i_addr[IDX_W-1:0];
  assign addr_in_tbl = i_addr[4] && (32'(i_addr[3:0]) < 32'(DEPTH));
  assign tbl_hit     = wr_en && addr_in_tbl;
  assign idle_next   = (wr_en && i_addr == ADDR_IDLE) ? i_write_data[GPO_W-1:0] : idle_val;

  // Stop beats start; a start with an illegal length is simply dropped.
  assign start_go = start_req && !stop_req && len_ok;
  assign step     = !stop_req && !start_go && (state == RUN) && tick &&
                    (dur_cnt[DUR_W-1:1] == '0);
  assign last     = ((5'(idx) + 5'd1) >= length) || (&idx);
  assign next_idx = idx + 1'b1;
  assign finish   = step && last && !loop_en;
  assign wrap     = step && last && loop_en;
  assign load     = start_go || (step && !finish);
  assign load_idx = start_go ? '0 : (last ? '0 : next_idx);

  gpo_seq_prescaler u_prescaler (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .limit (prescale),
    .enable(state == RUN),
    .clear (start_go),
    .tick  (tick)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (stop_req)      state_d = IDLE;
    else if (start_go) state_d = RUN;
    else if (finish)   state_d = IDLE;
  end

  always_comb begin
    gpo_d = o_gpo;
    if (state_d == IDLE) gpo_d = idle_next;
    else if (load)       gpo_d = tbl_val[load_idx];
  end

  // Sequencer datapath; table entries are sampled only at the moment they load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx      <= '0;
      dur_cnt  <= '0;
      loop_cnt <= '0;
      done     <= 1'b0;
      o_gpo    <= '0;
    end else begin
      o_gpo <= gpo_d;
      if (load) begin
        idx     <= load_idx;
        dur_cnt <= (tbl_dur[load_idx] == '0) ? DUR_W'(1) : tbl_dur[load_idx];
      end else if ((state == RUN) && tick && (dur_cnt[DUR_W-1:1] != '0)) begin
        dur_cnt <= dur_cnt - 1'b1;
      end
      if (start_go)  loop_cnt <= '0;
      else if (wrap) loop_cnt <= loop_cnt + 1'b1;
      if (finish)                   done <= 1'b1;
      else if (clr_req || start_go) done <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      loop_en  <= 1'b0;
      prescale <= '0;
      length   <= '0;
      idle_val <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tbl_val[k] <= '0;
        tbl_dur[k] <= '0;
      end
    end else begin
      if (ctrl_wr)                           loop_en  <= i_write_data[CTRL_LOOP];
      if (wr_en && i_addr == ADDR_PRESCALE) prescale <= i_write_data;
      if (wr_en && i_addr == ADDR_LENGTH)   length   <= i_write_data[4:0];
      if (wr_en && i_addr == ADDR_IDLE)     idle_val <= i_write_data[GPO_W-1:0];
      if (tbl_hit) begin
        tbl_val[rd_idx] <= i_write_data[GPO_W-1:0];
        tbl_dur[rd_idx] <= i_write_data[31:16];
      end
    end
  end

  always_comb begin
    o_read_data = '0;
    if (addr_in_tbl) begin
      o_read_data = {tbl_dur[rd_idx], 16'h0000} | 32'(tbl_val[rd_idx]);
    end else begin
      case (i_addr)
        ADDR_CTRL: begin
          o_read_data[CTRL_BUSY] = (state == RUN);
          o_read_data[CTRL_LOOP] = loop_en;
          o_read_data[CTRL_DONE] = done;
        end
        ADDR_PRESCALE: o_read_data = prescale;
        ADDR_LENGTH:   o_read_data = 32'(length);
        ADDR_STATUS:   o_read_data = {loop_cnt, 16'h0000} | 32'(idx);
        ADDR_IDLE:     o_read_data = 32'(idle_val);
        default:       o_read_data = '0;
      endcase
    end
  end

`ifdef GPO_SEQ_IRQ_EN
  assign o_irq = done;
`endif

endmodule

// File: doc/mmio_gpo_seq.md
Name: mmio_gpo_seq

Overview:
MMIO-slot pattern sequencer that owns the GPO output pins and drives them from a 16-entry table of (value, duration) pairs, without CPU involvement per step. Firmware loads the table, prescaler, length and mode, then issues start. The block steps through the entries on prescaled ticks, optionally looping. It sits on an MMIO slot next to the other slot cores; o_gpo goes to LEDs or pins.

Parameters:
GPO_W, 16, width of o_gpo (1..16); entry value field uses bits [GPO_W-1:0].
DEPTH, 16, table entries; fixed by the address map (addr 16..31); legal values 2..16, power of two.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  reset; asynchronous, active-low
i_cs  input  1  slot select
i_write  input  1  write strobe, qualified by i_cs
i_read  input  1  read strobe; no read side effects, ignored
i_addr  input  5  word address within slot
i_write_data  input  32  write data
o_read_data  output  32  combinational read mux on i_addr
o_gpo  output  GPO_W  registered pattern output

Behaviour:
- Write enable is i_cs & i_write. Unmapped addresses read 0 and ignore writes.
- Address map:
  - 0 CTRL: W bit0 start (pulse), bit1 stop (pulse), bit2 loop (stored), bit3 clear done (pulse). R: bit0 busy, bit2 loop, bit4 done.
  - 1 PRESCALE[31:0]: one tick every PRESCALE+1 clocks.
  - 2 LENGTH[4:0]: entries used; legal 1..DEPTH; 0 or >DEPTH means start is ignored.
  - 3 STATUS (R): [3:0] current index, [31:16] loop count (wraps at 0xFFFF).
  - 4 IDLE_VAL[GPO_W-1:0]: value driven while idle.
  - 16+k ENTRY[k]: [GPO_W-1:0] value, [31:16] duration in ticks; duration 0 is treated as 1.
- Reset: all registers, table, counters, state = IDLE, done = 0, o_gpo = 0. IDLE_VAL resets to 0.
- FSM states: IDLE and RUN.
- IDLE:
  - o_gpo = IDLE_VAL; a write to IDLE_VAL updates o_gpo on the next cycle.
  - A start write with legal LENGTH causes, on that edge: state <= RUN, idx <= 0, o_gpo <= ENTRY[0].value, dur_cnt <= max(ENTRY[0].dur, 1), pre_cnt <= 0, loop count <= 0, done <= 0.
- RUN:
  - pre_cnt increments each clock; a tick occurs when pre_cnt >= PRESCALE, and pre_cnt then returns to 0.
  - On a tick with dur_cnt > 1: dur_cnt is decremented.
  - On a tick with dur_cnt == 1, advance:
    - if idx < LENGTH-1: load idx+1 (value and duration) on the same edge.
    - if idx == LENGTH-1 and loop = 1: load entry 0 and increment loop count.
    - if idx == LENGTH-1 and loop = 0: state <= IDLE, o_gpo <= IDLE_VAL, done <= 1.
  - Each entry is therefore visible for dur×(PRESCALE+1) clocks.
- Stop write: IDLE at the next edge, o_gpo <= IDLE_VAL, done is not set.
- Start while RUN: restarts from entry 0. If start and stop are written together, stop wins.
- Table, LENGTH, PRESCALE and loop may be written during RUN:
  - an entry is sampled only when it is loaded;
  - a new LENGTH is compared at the next advance;
  - if the new LENGTH <= idx, the sequence ends (or wraps, if loop = 1) at the next advance;
  - a new PRESCALE applies from the next compare.
- Clear done and a set of done on the same edge: set wins.
- Asserting reset mid-RUN clears everything immediately (asynchronous).

Optional Feature:
Macro GPO_SEQ_IRQ_EN.
- Defined: adds output port o_irq (1 bit). o_irq is registered, equals done, and stays high until cleared via CTRL bit3 or a new start.
- Undefined: no o_irq port and no extra logic; done is visible only by polling CTRL.

Decomposition:
- Package gpo_seq_pkg:
  - state enum (IDLE, RUN);
  - address constants (ADDR_CTRL = 0, ADDR_PRESCALE = 1, ADDR_LENGTH = 2, ADDR_STATUS = 3, ADDR_IDLE = 4, ADDR_TABLE_BASE = 16);
  - CTRL bit indices;
  - DUR_W = 16.
- One sub-module, gpo_seq_prescaler:
  - inputs: 32-bit limit, enable, sync clear;
  - output: single-cycle tick.

Test Plan:
- Reset: assert i_reset_n = 0 mid-RUN → o_gpo = 0, CTRL reads 0, STATUS reads 0, immediately and asynchronously.
- One-shot run:
  - setup: PRESCALE = 1, LENGTH = 2, ENTRY0 = 0x0003_00AA, ENTRY1 = 0x0001_0055, IDLE_VAL = 0x000F, loop = 0, start;
  - expect o_gpo = 0xAA for 6 clocks, then 0x55 for 2 clocks, then 0x000F;
  - expect CTRL.done = 1 and busy = 0.
- Loop with zero duration:
  - setup: PRESCALE = 0, LENGTH = 3, durations 0, 2, 1, loop = 1;
  - expect a period of 1 + 2 + 1 clocks;
  - expect STATUS loop count = 5 after 20 clocks;
  - stop → o_gpo = IDLE_VAL next cycle, done stays 0.
- Illegal and concurrent control:
  - LENGTH = 0 with start → stays IDLE;
  - start+stop in one write → IDLE;
  - start during RUN → idx 0, loop count 0.
- Live edits:
  - shrink LENGTH from 4 to 1 while idx = 2, loop = 0 → ends at the next advance;
  - ENTRY writes to the current idx → o_gpo unchanged until the entry is reloaded.
- With GPO_SEQ_IRQ_EN: o_irq rises with done; CTRL bit3 write → o_irq = 0 next cycle; simultaneous set and clear → o_irq stays 1.
